// File: rtl/intra_mode_decider_if.sv
// Handshake bundle for the intra mode decider: candidate input,
// decision output, residue row stream and mode-table read port.
interface intra_mode_decider_if #(
    parameter int NUM_MODES = 9,
    parameter int SAD_W     = 16,
    parameter int RES_W     = 8,
    parameter int MB_SIZE_L = 8,
    parameter int MB_SIZE_W = 8,
    parameter int LAMBDA_W  = 4
);
    localparam int MODE_W   = $clog2(NUM_MODES);
    localparam int ROW_BITS = MB_SIZE_L * RES_W;
    localparam int RES_BITS = NUM_MODES * MB_SIZE_W * ROW_BITS;

    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_MODES*SAD_W-1:0] in_sads;
    logic [RES_BITS-1:0]        in_res;
    logic [12:0]                in_mbnumber;
    logic [LAMBDA_W-1:0]        lambda;

    logic                       out_valid;
    logic                       out_ready;
    logic [MODE_W-1:0]          out_mode;
    logic [SAD_W:0]             out_cost;
    logic                       out_err;

    logic                       res_valid;
    logic                       res_ready;
    logic [ROW_BITS-1:0]        res_row;
    logic [12:0]                res_x;
    logic [12:0]                res_y;
    logic                       res_last;

    logic [12:0]                mt_rd_addr;
    logic [MODE_W-1:0]          mt_rd_data;

    modport master (
        output in_valid, in_sads, in_res,
        output in_mbnumber, lambda,
        output out_ready, res_ready, mt_rd_addr,
        input  in_ready, out_valid, out_mode,
        input  out_cost, out_err,
        input  res_valid, res_row, res_x, res_y,
        input  res_last, mt_rd_data
    );

    modport slave (
        input  in_valid, in_sads, in_res,
        input  in_mbnumber, lambda,
        input  out_ready, res_ready, mt_rd_addr,
        output in_ready, out_valid, out_mode,
        output out_cost, out_err,
        output res_valid, res_row, res_x, res_y,
        output res_last, mt_rd_data
    );
endinterface

// File: rtl/intra_mode_decider.sv
// Picks the min-cost intra mode per macroblock, streams its residue
// rows and records the decision in a per-MB mode table.
module intra_mode_decider #(
    parameter int NUM_MODES = 9,
    parameter int SAD_W     = 16,
    parameter int RES_W     = 8,
    parameter int MB_SIZE_L = 8,
    parameter int MB_SIZE_W = 8,
    parameter int LENGTH    = 1280,
    parameter int WIDTH     = 720,
    parameter int LAMBDA_W  = 4
) (
    input logic                clk,
    input logic                reset,
    intra_mode_decider_if.slave bus
);
    localparam int MODE_W     = $clog2(NUM_MODES);
    localparam int CW         = SAD_W + 1;
    localparam int MB_PER_ROW = LENGTH / MB_SIZE_L;
    localparam int MB_COUNT   = MB_PER_ROW * (WIDTH / MB_SIZE_W);
    localparam int TW = (MB_COUNT > 1) ? $clog2(MB_COUNT) : 1;
    localparam int RW = (MB_SIZE_W > 1) ? $clog2(MB_SIZE_W) : 1;
    localparam int ROW_BITS = MB_SIZE_L * RES_W;
    localparam int RES_BITS = NUM_MODES * MB_SIZE_W * ROW_BITS;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        EMIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SAD_W-1:0]    sad_q [NUM_MODES];
    logic [RES_BITS-1:0] res_q;
    logic [LAMBDA_W-1:0] lambda_q;
    logic [TW-1:0]       mb_q;
    logic                err_q;
    logic [12:0]         x0_q;
    logic [12:0]         y0_q;

    logic [MODE_W-1:0]   k_q;
    logic [MODE_W-1:0]   best_mode;
    logic [CW-1:0]       best_cost;
    logic [MODE_W-1:0]   prev_mode;
    logic [RW-1:0]       row_q;

    logic [MODE_W-1:0]   mt [MB_COUNT];

    logic [CW-1:0]       cost_k;
    logic                take;
    logic [MODE_W-1:0]   win_mode;
    logic [CW-1:0]       win_cost;
    logic                last_k;
    logic                accept;
    logic                out_hs;
    logic                res_hs;
    logic [RW-1:0]       row_nxt;
    logic                row_last;
    logic                out_fin;
    logic                res_fin;
    logic                tab_we;

    // The mode that repeats the previous decision carries no penalty.
    assign cost_k = {1'b0, sad_q[k_q]}
                  + ((k_q == prev_mode) ? '0 : CW'(lambda_q));
    assign take     = (k_q == '0) || (cost_k < best_cost);
    assign win_mode = take ? k_q : best_mode;
    assign win_cost = take ? cost_k : best_cost;
    assign last_k   = (k_q == MODE_W'(NUM_MODES - 1));

    assign accept   = (state == IDLE) && bus.in_valid;
    assign out_hs   = bus.out_valid && bus.out_ready;
    assign res_hs   = bus.res_valid && bus.res_ready;
    assign row_nxt  = row_q + RW'(1);
    assign row_last = (row_q == RW'(MB_SIZE_W - 1));
    assign out_fin  = !bus.out_valid || out_hs;
    assign res_fin  = !bus.res_valid || (res_hs && row_last);
    assign tab_we   = (state == EVAL) && last_k && !err_q;

    function automatic logic [ROW_BITS-1:0] pick_row(
        input logic [MODE_W-1:0] m,
        input logic [RW-1:0]     r
    );
        int base;
        base = (int'(m) * MB_SIZE_W + int'(r)) * ROW_BITS;
        return res_q[base +: ROW_BITS];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = EVAL;
            EVAL: if (last_k) state_nxt = EMIT;
            EMIT: if (out_fin && res_fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == IDLE);
    end

    // Candidate capture has no reset; it is only read after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int m = 0; m < NUM_MODES; m++) begin
                sad_q[m] <= bus.in_sads[m*SAD_W +: SAD_W];
            end
            res_q    <= bus.in_res;
            lambda_q <= bus.lambda;
            mb_q     <= TW'(bus.in_mbnumber);
            err_q    <= int'(bus.in_mbnumber) >= MB_COUNT;
            x0_q <= 13'((int'(bus.in_mbnumber) % MB_PER_ROW)
                        * MB_SIZE_L);
            y0_q <= 13'((int'(bus.in_mbnumber) / MB_PER_ROW)
                        * MB_SIZE_W);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_mode  <= '0;
            bus.out_cost  <= '0;
            bus.out_err   <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_row   <= '0;
            bus.res_x     <= '0;
            bus.res_y     <= '0;
            bus.res_last  <= 1'b0;
            k_q           <= '0;
            best_mode     <= '0;
            best_cost     <= '0;
            prev_mode     <= '0;
            row_q         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    k_q <= '0;
                end
                EVAL: begin
                    best_mode <= win_mode;
                    best_cost <= win_cost;
                    k_q       <= k_q + MODE_W'(1);
                    if (last_k) begin
                        bus.out_valid <= 1'b1;
                        bus.out_mode  <= win_mode;
                        bus.out_cost  <= win_cost;
                        bus.out_err   <= err_q;
                        bus.res_valid <= 1'b1;
                        bus.res_row   <= pick_row(win_mode, '0);
                        bus.res_x     <= x0_q;
                        bus.res_y     <= y0_q;
                        bus.res_last  <= (MB_SIZE_W == 1);
                        row_q         <= '0;
                        if (!err_q) prev_mode <= win_mode;
                    end
                end
                EMIT: begin
                    if (out_hs) bus.out_valid <= 1'b0;
                    if (res_hs) begin
                        if (row_last) begin
                            bus.res_valid <= 1'b0;
                            bus.res_last  <= 1'b0;
                        end else begin
                            row_q        <= row_nxt;
                            bus.res_row  <=
                                pick_row(bus.out_mode, row_nxt);
                            bus.res_y    <= bus.res_y + 13'd1;
                            bus.res_last <=
                                (row_nxt == RW'(MB_SIZE_W - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tab_we) mt[mb_q] <= win_mode;
    end

    // Read register sees the pre-write table contents on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mt_rd_data <= '0;
        end else if (int'(bus.mt_rd_addr) < MB_COUNT) begin
            bus.mt_rd_data <= mt[TW'(bus.mt_rd_addr)];
        end else begin
            bus.mt_rd_data <= '0;
        end
    end
endmodule
